mem_port_arbiter: RTL

//  Shares the single synchronous memory port between the CPU control unit/datapath
//  (opcode, address-byte and operand fetches, STAC writes) and a debug/program-loader port.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for the shared memory port: CPU requester, debug requester and memory side.
// The arbiter uses the slave view; the surrounding system (or bench) uses the master view.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;

   logic              dbg_req;
   logic              dbg_lock;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_gnt;
   logic [DATA_W-1:0] dbg_rdata;
   logic              dbg_rvalid;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rdata, cpu_rvalid,
      input  dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rdata, dbg_rvalid,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rdata, cpu_rvalid,
      output dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rdata, dbg_rvalid,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single synchronous memory port between the CPU and a debug/loader port,
// with a debug starvation limit, locked debug bursts capped for CPU fairness, and read routing.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned MAX_BURST    = 8
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned BurstW  = $clog2(MAX_BURST + 1);
   localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
   localparam logic [BurstW-1:0]  BurstMax  = BurstW'(MAX_BURST);

   typedef enum logic [1:0] {StIdle, StCpu, StDbg} state_e;

   state_e             state_q, state_d;
   logic [StarveW-1:0] starve_q, starve_d;
   logic [BurstW-1:0]  burst_q, burst_d;
   logic               cpu_rvalid_q, cpu_rvalid_d;
   logic               dbg_rvalid_q, dbg_rvalid_d;

   logic              cpu_req, dbg_req;
   logic              gnt_cpu, gnt_dbg;
   logic              mux_we;
   logic [ADDR_W-1:0] mux_addr;
   logic [DATA_W-1:0] mux_wdata;

   // Requests are masked during reset so every combinational output is held at 0.
   assign cpu_req = bus.cpu_req & ~reset;
   assign dbg_req = bus.dbg_req & ~reset;

   always_comb begin : grant_logic
      gnt_cpu = 1'b0;
      gnt_dbg = 1'b0;
      if (state_q == StDbg && bus.dbg_lock && dbg_req && (burst_q < BurstMax || !cpu_req)) begin
         gnt_dbg = 1'b1;
      end else if (dbg_req && starve_q == StarveMax) begin
         gnt_dbg = 1'b1;
      end else if (cpu_req) begin
         gnt_cpu = 1'b1;
      end else if (dbg_req) begin
         gnt_dbg = 1'b1;
      end
   end

   always_comb begin : next_state
      state_d = StIdle;
      if (gnt_cpu) begin
         state_d = StCpu;
      end else if (gnt_dbg) begin
         state_d = StDbg;
      end

      starve_d = '0;
      if (dbg_req && !gnt_dbg) begin
         starve_d = (starve_q == StarveMax) ? starve_q : starve_q + StarveW'(1);
      end

      // A burst starts at 1 on a fresh debug grant and only grows while debug keeps the port.
      burst_d = '0;
      if (gnt_dbg) begin
         if (state_q != StDbg) begin
            burst_d = BurstW'(1);
         end else if (burst_q != BurstMax) begin
            burst_d = burst_q + BurstW'(1);
         end else begin
            burst_d = burst_q;
         end
      end

      cpu_rvalid_d = gnt_cpu & ~bus.cpu_we;
      dbg_rvalid_d = gnt_dbg & ~bus.dbg_we;
   end

   always_comb begin : port_mux
      mux_we    = 1'b0;
      mux_addr  = '0;
      mux_wdata = '0;
      if (gnt_cpu) begin
         mux_we    = bus.cpu_we;
         mux_addr  = bus.cpu_addr;
         mux_wdata = bus.cpu_wdata;
      end else if (gnt_dbg) begin
         mux_we    = bus.dbg_we;
         mux_addr  = bus.dbg_addr;
         mux_wdata = bus.dbg_wdata;
      end
   end

   assign bus.mem_en    = gnt_cpu | gnt_dbg;
   assign bus.mem_we    = mux_we;
   assign bus.mem_addr  = mux_addr;
   assign bus.mem_wdata = mux_wdata;

   assign bus.cpu_stall  = cpu_req & ~gnt_cpu;
   assign bus.dbg_gnt    = gnt_dbg;
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.dbg_rvalid = dbg_rvalid_q;
   assign bus.cpu_rdata  = cpu_rvalid_q ? bus.mem_rdata : '0;
   assign bus.dbg_rdata  = dbg_rvalid_q ? bus.mem_rdata : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         starve_q     <= '0;
         burst_q      <= '0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         burst_q      <= burst_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         dbg_rvalid_q <= dbg_rvalid_d;
      end
   end
endmodule
